// File: rtl/lsu_pkg.sv
// Shared types and encodings for the load/store unit: FSM states, RV32I
// width codes and fault codes reported with the completion pulse.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    localparam logic [1:0] FLT_OK       = 2'b00;
    localparam logic [1:0] FLT_MISALIGN = 2'b01;
    localparam logic [1:0] FLT_TIMEOUT  = 2'b10;
    localparam logic [1:0] FLT_ILLEGAL  = 2'b11;

endpackage

// File: rtl/lsu_load_extract.sv
// Picks the addressed byte/halfword out of a read word and sign- or
// zero-extends it; purely combinational so a cache path can share it.
module lsu_load_extract
    import lsu_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  lane_i,
    output logic [31:0] data_o
);

    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;

    always_comb begin
        byte_s = rdata_i[8*lane_i +: 8];
        half_s = rdata_i[16*lane_i[1] +: 16];
        case (funct3_i)
            F3_B:    data_o = 32'(byte_s);
            F3_BU:   data_o = {24'b0, byte_s};
            F3_H:    data_o = 32'(half_s);
            F3_HU:   data_o = {16'b0, half_s};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: accepts an ALU effective address, runs one
// req/ack transaction against data memory and reports data plus fault.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_lsu_valid,
    input  logic        i_lsu_wren,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_st_data,
    output logic        o_lsu_busy,
    output logic        o_lsu_done,
    output logic [31:0] o_ld_data,
    output logic [1:0]  o_fault,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_bmask,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    lsu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       f3_q, f3_d;
    logic [29:0]      word_q, word_d;
    logic [1:0]       lane_q, lane_d;
    logic             we_q, we_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       bmask_q, bmask_d;
    logic [31:0]      ld_q, ld_d;
    logic [1:0]       fault_q, fault_d;

    logic [31:0]      ext_data;
    logic [3:0]       acc_bmask;
    logic [31:0]      acc_wdata;
    logic             acc_illegal;
    logic             acc_misalign;
    logic             timed_out;

    lsu_load_extract u_extract (
        .rdata_i  (i_mem_rdata),
        .funct3_i (f3_q),
        .lane_i   (lane_q),
        .data_o   (ext_data)
    );

    // Classification and lane steering of the incoming access
    always_comb begin
        acc_illegal  = i_lsu_wren ? (i_funct3 >= 3'd3)
                                  : (i_funct3 == 3'd3 || i_funct3 == 3'd6 || i_funct3 == 3'd7);
        acc_misalign = ((i_funct3[1:0] == 2'b01) && i_addr[0])
                     || ((i_funct3[1:0] == 2'b10) && (i_addr[1:0] != 2'b00));
        case (i_funct3[1:0])
            2'b00: begin
                acc_bmask = 4'b0001 << i_addr[1:0];
                acc_wdata = {4{i_st_data[7:0]}};
            end
            2'b01: begin
                acc_bmask = i_addr[1] ? 4'b1100 : 4'b0011;
                acc_wdata = {2{i_st_data[15:0]}};
            end
            default: begin
                acc_bmask = 4'b1111;
                acc_wdata = i_st_data;
            end
        endcase
        if (!i_lsu_wren) begin
            acc_bmask = 4'b1111;
            acc_wdata = '0;
        end
    end

    assign timed_out = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        f3_d    = f3_q;
        word_d  = word_q;
        lane_d  = lane_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        bmask_d = bmask_q;
        ld_d    = ld_q;
        fault_d = fault_q;
        case (state_q)
            IDLE: begin
                if (i_lsu_valid) begin
                    f3_d    = i_funct3;
                    word_d  = i_addr[31:2];
                    lane_d  = i_addr[1:0];
                    we_d    = i_lsu_wren;
                    wdata_d = acc_wdata;
                    bmask_d = acc_bmask;
                    ld_d    = '0;
                    cnt_d   = '0;
                    if (acc_illegal) begin
                        fault_d = FLT_ILLEGAL;
                        state_d = DONE;
                    end else if (acc_misalign) begin
                        fault_d = FLT_MISALIGN;
                        state_d = DONE;
                    end else begin
                        fault_d = FLT_OK;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                // An ack arriving on the final counted cycle still completes normally
                if (i_mem_ack) begin
                    ld_d    = we_q ? '0 : ext_data;
                    fault_d = FLT_OK;
                    state_d = DONE;
                end else if (timed_out) begin
                    ld_d    = '0;
                    fault_d = FLT_TIMEOUT;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            f3_q    <= '0;
            word_q  <= '0;
            lane_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            bmask_q <= '0;
            ld_q    <= '0;
            fault_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            f3_q    <= f3_d;
            word_q  <= word_d;
            lane_q  <= lane_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            bmask_q <= bmask_d;
            ld_q    <= ld_d;
            fault_q <= fault_d;
        end
    end

    assign o_lsu_busy  = (state_q != IDLE);
    assign o_lsu_done  = (state_q == DONE);
    assign o_mem_req   = (state_q == REQ);
    assign o_mem_we    = we_q;
    assign o_mem_addr  = {word_q, 2'b00};
    assign o_mem_wdata = wdata_q;
    assign o_mem_bmask = bmask_q;
    assign o_ld_data   = ld_q;
    assign o_fault     = fault_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: expected completions are queued at issue
// time and compared when the done pulse appears.
module tb_lsu_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        i_reset;
    logic        i_lsu_valid;
    logic        i_lsu_wren;
    logic [2:0]  i_funct3;
    logic [31:0] i_addr;
    logic [31:0] i_st_data;
    logic        o_lsu_busy;
    logic        o_lsu_done;
    logic [31:0] o_ld_data;
    logic [1:0]  o_fault;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_bmask;
    logic        i_mem_ack;
    logic [31:0] i_mem_rdata;

    always #5 clk = ~clk;

    lsu_ctrl #(.TIMEOUT(TO), .CNT_W(8)) dut (
        .i_clk       (clk),
        .i_reset     (i_reset),
        .i_lsu_valid (i_lsu_valid),
        .i_lsu_wren  (i_lsu_wren),
        .i_funct3    (i_funct3),
        .i_addr      (i_addr),
        .i_st_data   (i_st_data),
        .o_lsu_busy  (o_lsu_busy),
        .o_lsu_done  (o_lsu_done),
        .o_ld_data   (o_ld_data),
        .o_fault     (o_fault),
        .o_mem_req   (o_mem_req),
        .o_mem_we    (o_mem_we),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .o_mem_bmask (o_mem_bmask),
        .i_mem_ack   (i_mem_ack),
        .i_mem_rdata (i_mem_rdata)
    );

    typedef struct packed {
        logic [31:0] ld;
        logic [1:0]  flt;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issues one access and follows it to completion, acking on REQ cycle
    // ack_after+1 (negative = never ack).
    task automatic access(input string tag, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] st,
                          input int ack_after, input logic [31:0] rd,
                          input logic [31:0] exp_ld, input logic [1:0] exp_flt,
                          input int exp_reqs, input int exp_done,
                          input logic [3:0] exp_bm, input logic [31:0] exp_wd,
                          input bit pulse_valid);
        int   cyc;
        int   reqs;
        int   bad;
        int   done_cyc;
        bit   got;
        exp_t e;
        @(negedge clk);
        i_lsu_valid = 1'b1;
        i_lsu_wren  = wr;
        i_funct3    = f3;
        i_addr      = a;
        i_st_data   = st;
        sb_q.push_back('{ld: exp_ld, flt: exp_flt});
        @(negedge clk);
        i_lsu_valid = 1'b0;
        i_addr      = $urandom;
        i_st_data   = $urandom;
        cyc = 1; reqs = 0; bad = 0; done_cyc = -1; got = 1'b0;
        while (!got && cyc <= 40) begin
            i_mem_ack   = 1'b0;
            i_lsu_valid = 1'b0;
            i_mem_rdata = $urandom;
            if (o_mem_req) begin
                reqs++;
                if (o_mem_addr !== {a[31:2], 2'b00} || o_mem_we !== wr ||
                    o_mem_bmask !== exp_bm || o_mem_wdata !== exp_wd)
                    bad++;
                if (ack_after >= 0 && reqs == ack_after + 1) begin
                    i_mem_ack   = 1'b1;
                    i_mem_rdata = rd;
                end
                if (pulse_valid && reqs == 2) i_lsu_valid = 1'b1;
            end
            if (o_lsu_done) begin
                got      = 1'b1;
                done_cyc = cyc;
                e        = sb_q.pop_front();
                chk({tag, ".ld_data"}, o_ld_data, e.ld);
                chk({tag, ".fault"}, {30'b0, o_fault}, {30'b0, e.flt});
            end
            @(negedge clk);
            cyc++;
        end
        i_mem_ack   = 1'b0;
        i_lsu_valid = 1'b0;
        chk({tag, ".done_seen"}, {31'b0, got}, 32'd1);
        chk({tag, ".mem_outputs"}, bad, 0);
        chk({tag, ".req_cycles"}, reqs, exp_reqs);
        chk({tag, ".done_cycle"}, done_cyc, exp_done);
        chk({tag, ".idle_after"}, {31'b0, o_lsu_busy}, 32'd0);
        chk({tag, ".ld_hold"}, o_ld_data, exp_ld);
    endtask

    initial begin
        int dn;
        i_reset     = 1'b1;
        i_lsu_valid = 1'b0;
        i_lsu_wren  = 1'b0;
        i_funct3    = '0;
        i_addr      = '0;
        i_st_data   = '0;
        i_mem_ack   = 1'b0;
        i_mem_rdata = '0;
        repeat (2) @(negedge clk);
        chk("reset.req", {31'b0, o_mem_req}, 32'd0);
        chk("reset.busy", {31'b0, o_lsu_busy}, 32'd0);
        chk("reset.done", {31'b0, o_lsu_done}, 32'd0);
        chk("reset.outs", o_ld_data | o_mem_addr | o_mem_wdata
                          | {26'b0, o_fault, o_mem_bmask}, 32'd0);
        i_reset = 1'b0;

        access("lb_sext",  1'b0, 3'd0, 32'h0000_1003, 32'h0, 0, 32'h80AA_BBCC,
               32'hFFFF_FF80, 2'b00, 1, 2, 4'hF, 32'h0, 1'b0);
        access("lbu_lane1", 1'b0, 3'd4, 32'h0000_1001, 32'h0, 0, 32'h80AA_BBCC,
               32'h0000_00BB, 2'b00, 1, 2, 4'hF, 32'h0, 1'b0);
        access("lhu",      1'b0, 3'd5, 32'h0000_2002, 32'h0, 0, 32'h9123_4567,
               32'h0000_9123, 2'b00, 1, 2, 4'hF, 32'h0, 1'b0);
        access("lh",       1'b0, 3'd1, 32'h0000_2002, 32'h0, 0, 32'h9123_4567,
               32'hFFFF_9123, 2'b00, 1, 2, 4'hF, 32'h0, 1'b0);
        access("sb",       1'b1, 3'd0, 32'h0000_3001, 32'h0000_00A5, 0, 32'hFFFF_FFFF,
               32'h0, 2'b00, 1, 2, 4'b0010, 32'hA5A5_A5A5, 1'b0);
        access("sh",       1'b1, 3'd1, 32'h0000_3002, 32'h1234_BEEF, 1, 32'hFFFF_FFFF,
               32'h0, 2'b00, 2, 3, 4'b1100, 32'hBEEF_BEEF, 1'b0);
        access("sw",       1'b1, 3'd2, 32'h0000_6000, 32'h1122_3344, 0, 32'h0,
               32'h0, 2'b00, 1, 2, 4'hF, 32'h1122_3344, 1'b0);
        access("lw_misal", 1'b0, 3'd2, 32'h0000_4002, 32'h0, 0, 32'h0,
               32'h0, 2'b01, 0, 1, 4'h0, 32'h0, 1'b0);
        access("sb_illeg", 1'b1, 3'd3, 32'h0000_4000, 32'h0, 0, 32'h0,
               32'h0, 2'b11, 0, 1, 4'h0, 32'h0, 1'b0);
        access("lw_late_ack", 1'b0, 3'd2, 32'h0000_5004, 32'h0, 3, 32'hDEAD_BEEF,
               32'hDEAD_BEEF, 2'b00, 4, 5, 4'hF, 32'h0, 1'b1);
        access("lw_timeout", 1'b0, 3'd2, 32'h0000_5000, 32'h0, -1, 32'h0,
               32'h0, 2'b10, TO, TO + 1, 4'hF, 32'h0, 1'b0);

        // Asynchronous reset during an outstanding request
        @(negedge clk);
        i_lsu_valid = 1'b1; i_lsu_wren = 1'b0; i_funct3 = 3'd2; i_addr = 32'h0000_7000;
        @(negedge clk);
        i_lsu_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid.req_before", {31'b0, o_mem_req}, 32'd1);
        #2 i_reset = 1'b1;
        #1;
        chk("rst_mid.req_drop", {31'b0, o_mem_req}, 32'd0);
        chk("rst_mid.busy_drop", {31'b0, o_lsu_busy}, 32'd0);
        @(negedge clk);
        i_reset = 1'b0;
        dn = 0;
        repeat (4) begin
            @(negedge clk);
            if (o_lsu_done) dn++;
        end
        chk("rst_mid.no_done", dn, 0);

        access("post_rst_lb", 1'b0, 3'd0, 32'h0000_1003, 32'h0, 0, 32'h80AA_BBCC,
               32'hFFFF_FF80, 2'b00, 1, 2, 4'hF, 32'h0, 1'b0);
        chk("scoreboard.empty", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
